// File: rtl/tally_pkg.sv
// Purpose: shared types and constants for the tally accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tally_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Largest possible frame total: every sample reports all n inputs active.
    function automatic int popcount_max(input int n, input int frame);
        return n * frame;
    endfunction

endpackage

// File: rtl/tally_onehot_dec.sv
// Purpose: decode a one-hot count vector (bit k set = k inputs active) to binary.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of in_tally.
// Ports: in_tally (N+1 one-hot), value (decoded k, 0 when malformed),
//        malformed (zero or several bits set).
module tally_onehot_dec #(
    parameter int N = 6,
    localparam int VW = $clog2(N + 1)
) (
    input  logic [N:0]    in_tally,
    output logic [VW-1:0] value,
    output logic          malformed
);

    always_comb begin
        value     = '0;
        malformed = ($countones(in_tally) != 1);
        for (int i = 0; i <= N; i++) begin
            if (in_tally[i]) begin
                value = VW'(i);
            end
        end
        // A malformed vector must contribute nothing to the frame total.
        if (malformed) begin
            value = '0;
        end
    end

endmodule

// File: rtl/tally_accum.sv
// Purpose: accumulate FRAME decoded tally samples into a frame total with majority/error flags.
// Latency: result valid the cycle after the FRAME-th accepted sample.
// Backpressure: in_ready drops while a result waits for out_ready; clear aborts the frame.
// Ports: clk/rst_n (async active-low), clear (sync abort), in_valid/in_ready/in_tally
//        (sample input), out_valid/out_ready/out_sum/out_majority/out_err (frame result).
module tally_accum
    import tally_pkg::*;
#(
    parameter int N     = 6,
    parameter int FRAME = 16,
    localparam int SUMW = $clog2(popcount_max(N, FRAME) + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N:0]      in_tally,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SUMW-1:0] out_sum,
    output logic            out_majority,
    output logic            out_err
);

    localparam int VW = $clog2(N + 1);
    localparam int CW = $clog2(FRAME);
    // Majority compares 2*sum against N*FRAME on one extra bit so 2*sum cannot overflow.
    localparam logic [SUMW:0] MAJ_LIMIT = (SUMW + 1)'(popcount_max(N, FRAME));

    state_t          state_q,     state_d;
    logic [SUMW-1:0] acc_q,       acc_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            err_q,       err_d;
    logic            out_valid_q, out_valid_d;
    logic [SUMW-1:0] out_sum_q,   out_sum_d;
    logic            out_maj_q,   out_maj_d;
    logic            out_err_q,   out_err_d;

    logic [VW-1:0]   dec_value;
    logic            dec_malformed;
    logic [SUMW-1:0] sum_next;
    logic [SUMW:0]   sum_dbl;
    logic            accept;

    tally_onehot_dec #(
        .N (N)
    ) u_dec (
        .in_tally  (in_tally),
        .value     (dec_value),
        .malformed (dec_malformed)
    );

    assign in_ready = (state_q == ACC) && !clear;
    assign accept   = in_valid && in_ready;
    // acc never exceeds N*FRAME, so this add cannot wrap in SUMW bits.
    assign sum_next = acc_q + SUMW'(dec_value);
    assign sum_dbl  = {sum_next, 1'b0};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_maj_d   = out_maj_q;
        out_err_d   = out_err_q;

        if (clear) begin
            // Abort wins over any same-cycle accept or result handshake.
            state_d     = ACC;
            acc_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_d = sum_next;
                        cnt_d = cnt_q + 1'b1;
                        err_d = err_q | dec_malformed;
                        if (cnt_q == CW'(FRAME - 1)) begin
                            out_sum_d   = sum_next;
                            out_maj_d   = (sum_dbl > MAJ_LIMIT);
                            out_err_d   = err_q | dec_malformed;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        state_d     = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_maj_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_maj_q   <= out_maj_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_majority = out_maj_q;
    assign out_err      = out_err_q;

endmodule

// File: tb/tb_tally_accum.sv
// Purpose: self-checking bench for tally_accum with N=6, FRAME=4.
// Latency: n/a.
// Backpressure: exercises held results, clear aborts and mid-cycle reset.
module tb_tally_accum;

    localparam int N     = 6;
    localparam int FRAME = 4;
    localparam int SUMW  = $clog2(N * FRAME + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N:0]      in_tally = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SUMW-1:0] out_sum;
    logic            out_majority;
    logic            out_err;

    int checks   = 0;
    int failures = 0;

    tally_accum #(
        .N     (N),
        .FRAME (FRAME)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tally     (in_tally),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_majority (out_majority),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_bad(input logic [N:0] t);
        return $countones(t) != 1;
    endfunction

    function automatic int count_of(input logic [N:0] t);
        if (is_bad(t)) return 0;
        for (int i = 0; i <= N; i++) if (t[i]) return i;
        return 0;
    endfunction

    int m_samples;       // samples taken in the current frame
    int m_sum;
    bit m_err;
    bit m_hold;          // a finished frame result is waiting
    int m_res_sum;
    bit m_res_maj;
    bit m_res_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_samples = 0; m_sum = 0; m_err = 0; m_hold = 0;
            m_res_sum = 0; m_res_maj = 0; m_res_err = 0;
        end else if (clear) begin
            m_samples = 0; m_sum = 0; m_err = 0; m_hold = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_sum     = m_sum + count_of(in_tally);
                m_err     = m_err | is_bad(in_tally);
                m_samples = m_samples + 1;
                if (m_samples == FRAME) begin
                    m_res_sum = m_sum;
                    m_res_maj = (2 * m_sum) > (N * FRAME);
                    m_res_err = m_err;
                    m_hold    = 1;
                end
            end
        end else if (out_ready) begin
            m_hold = 0; m_samples = 0; m_sum = 0; m_err = 0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", int'(in_ready), int'(!m_hold && !clear));
            chk("cyc_out_valid", int'(out_valid), int'(m_hold));
            if (m_hold) begin
                chk("cyc_out_sum", int'(out_sum), m_res_sum);
                chk("cyc_out_majority", int'(out_majority), int'(m_res_maj));
                chk("cyc_out_err", int'(out_err), int'(m_res_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [N:0] t);
        bit done = 0;
        in_valid = 1'b1;
        in_tally = t;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) timeout("send_accept");
    endtask

    task automatic send4(input logic [N:0] t);
        for (int i = 0; i < 4; i++) send(t);
    endtask

    task automatic expect_result(input string name, input int s, input int maj, input int err);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) begin
            timeout({name, "_valid"});
        end else begin
            chk({name, "_sum"}, int'(out_sum), s);
            chk({name, "_majority"}, int'(out_majority), maj);
            chk({name, "_err"}, int'(out_err), err);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({name, "_drop_valid"}, int'(out_valid), 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_sum", int'(out_sum), 0);

        // Basic frame: 2+3+6+0 = 11, 22 > 24 is false.
        send(7'b0000100);
        send(7'b0001000);
        send(7'b1000000);
        send(7'b0000001);
        chk("basic_latency_valid", int'(out_valid), 1);
        expect_result("basic", 11, 0, 0);

        // Full vote and a tie.
        send4(7'b1000000);
        expect_result("full", 24, 1, 0);
        send4(7'b0001000);
        expect_result("tie", 12, 0, 0);

        // Malformed samples contribute 0 and raise err; it does not leak into the next frame.
        send(7'b0000110);
        send(7'b0000000);
        send(7'b0000010);
        send(7'b0000100);
        expect_result("malformed", 3, 0, 1);
        send4(7'b0000010);
        expect_result("after_malformed", 4, 0, 0);

        // Backpressure: result held 5 cycles with a sample offered the whole time.
        send4(7'b0000001);
        @(negedge clk);
        chk("bp_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_tally = 7'b1000000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_sum", int'(out_sum), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send4(7'b1000000);
        expect_result("bp_next", 24, 1, 0);

        // Abort after two 6s; the sample offered with clear is dropped.
        send(7'b1000000);
        send(7'b1000000);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_tally = 7'b1000000;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        send4(7'b0000010);
        expect_result("abort", 4, 0, 0);

        // Clear discards a pending result.
        send4(7'b0010000);
        @(negedge clk);
        chk("hold_before_clear", int'(out_valid), 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_drops_valid", int'(out_valid), 0);

        // Asynchronous reset mid-cycle while a result is held.
        send4(7'b1000000);
        @(negedge clk);
        chk("pre_reset_sum", int'(out_sum), 24);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_out_sum", int'(out_sum), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send4(7'b0000100);
        expect_result("post_reset", 8, 0, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
